ifmap_mem_node_sync: RTL and testbench

Clocked, parametrised input-feature-map memory node for the spiking-conv NoC. It buffers binary spike maps of `IF_SIZE`×`IF_SIZE` bits for `TIMESTEPS` timesteps, written one bit at a time. After loading completes, it streams one NoC packet per (timestep, row) toward a group of `NUM_DEST` PE nodes. Packets are sent round-robin (unicast) or replicated to every destination (broadcast). It replaces the single-size, two-timestep handshake-only memory node and adds a synchronous valid/ready interface, multi-destination modes and address-error detection.

---
 rtl/ifmap_mem_node_sync.sv | 173 +++++++++++++++++
 tb/tb_ifmap_mem_node_sync.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_mem_node_sync.sv
`default_nettype none
// ============================================================================
// Module  : ifmap_mem_node_sync
// Brief   : Bit-addressed multi-timestep ifmap buffer that streams one NoC
//           packet per (timestep, row) to a PE group, unicast or broadcast.
// Revision: 1.0 - initial release
// ============================================================================
module ifmap_mem_node_sync #(
  parameter int IF_SIZE   = 25,
  parameter int TIMESTEPS = 2,
  parameter int NUM_DEST  = 5,
  parameter int NODE      = 12,
  parameter int DEST_BASE = 1,
  parameter int NODE_W    = 4,
  parameter int TS_W      = 2,
  parameter int ADDR_W    = 10,
  parameter int ROW_W     = 5,
  parameter int PKT_W     = 2*NODE_W + TS_W + ROW_W + IF_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              mode,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [TS_W-1:0]   wr_ts,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_data,
  output logic              busy,
  output logic              send_done,
  output logic              err_addr
);

  localparam logic [ADDR_W:0]   c_area     = (ADDR_W+1)'(IF_SIZE*IF_SIZE);
  localparam logic [TS_W:0]     c_ts_lim   = (TS_W+1)'(TIMESTEPS);
  localparam logic [TS_W-1:0]   c_ts_last  = TS_W'(TIMESTEPS-1);
  localparam logic [ROW_W-1:0]  c_row_last = ROW_W'(IF_SIZE-1);
  localparam logic [NODE_W-1:0] c_dst_last = NODE_W'(NUM_DEST-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IF_SIZE-1:0] r_mem [TIMESTEPS][IF_SIZE];
  logic [TS_W-1:0]    r_ts;
  logic [ROW_W-1:0]   r_row;
  logic [NODE_W-1:0]  r_dst;
  logic [NODE_W-1:0]  r_umod;
  logic               r_mode;
  logic               r_send_done;
  logic               r_err;

  logic               w_addr_ok;
  logic               w_we;
  logic               w_clear;
  logic [ROW_W-1:0]   w_wrow;
  logic [ROW_W-1:0]   w_wcol;
  logic               w_xfer;
  logic               w_end;
  logic [IF_SIZE-1:0] w_payload;
  logic [NODE_W-1:0]  w_dest;

  assign wr_ready  = (r_state == S_LOAD);
  assign pkt_valid = (r_state == S_SEND);
  assign busy      = (r_state != S_IDLE);
  assign send_done = r_send_done;
  assign err_addr  = r_err;

  assign w_addr_ok = ({1'b0, wr_addr} < c_area) && ({1'b0, wr_ts} < c_ts_lim);
  assign w_we      = (r_state == S_LOAD) && wr_valid && w_addr_ok;
  assign w_clear   = (r_state == S_IDLE) && load_start;
  assign w_wrow    = ROW_W'(wr_addr / ADDR_W'(IF_SIZE));
  assign w_wcol    = ROW_W'(wr_addr % ADDR_W'(IF_SIZE));
  assign w_xfer    = pkt_valid && pkt_ready;
  assign w_end     = (r_row == c_row_last) && (r_ts == c_ts_last) &&
                     (!r_mode || (r_dst == c_dst_last));
  assign w_dest    = NODE_W'(DEST_BASE) + (r_mode ? r_dst : r_umod);
  assign pkt_data  = pkt_valid ? {w_dest, NODE_W'(NODE), r_ts, r_row, w_payload}
                               : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load_start) w_next = S_LOAD;
      S_LOAD:  if (load_done) w_next = S_SEND;
      S_SEND:  if (w_xfer && w_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Row read mux written as a decode so index widths never depend on parameters.
  always_comb begin
    w_payload = '0;
    for (int t = 0; t < TIMESTEPS; t++) begin
      for (int r = 0; r < IF_SIZE; r++) begin
        if (r_ts == TS_W'(t) && r_row == ROW_W'(r)) w_payload = r_mem[t][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int t = 0; t < TIMESTEPS; t++) begin
        for (int r = 0; r < IF_SIZE; r++) r_mem[t][r] <= '0;
      end
    end else if (w_we) begin
      for (int t = 0; t < TIMESTEPS; t++) begin
        for (int r = 0; r < IF_SIZE; r++) begin
          for (int c = 0; c < IF_SIZE; c++) begin
            if (wr_ts == TS_W'(t) && w_wrow == ROW_W'(r) && w_wcol == ROW_W'(c))
              r_mem[t][r][c] <= wr_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts        <= '0;
      r_row       <= '0;
      r_dst       <= '0;
      r_umod      <= '0;
      r_mode      <= 1'b0;
      r_send_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_send_done <= (r_state == S_SEND) && w_xfer && w_end;

      if (w_clear) r_err <= 1'b0;
      else if ((r_state == S_LOAD) && wr_valid && !w_addr_ok) r_err <= 1'b1;

      if ((r_state == S_LOAD) && load_done) begin
        r_mode <= mode;
        r_ts   <= '0;
        r_row  <= '0;
        r_dst  <= '0;
        r_umod <= '0;
      end else if ((r_state == S_SEND) && w_xfer) begin
        // Broadcast walks all destinations before moving to the next row.
        if (r_mode && (r_dst != c_dst_last)) begin
          r_dst <= r_dst + NODE_W'(1);
        end else begin
          r_dst <= '0;
          if (r_row == c_row_last) begin
            r_row  <= '0;
            r_umod <= '0;
            r_ts   <= (r_ts == c_ts_last) ? '0 : r_ts + TS_W'(1);
          end else begin
            r_row  <= r_row + ROW_W'(1);
            r_umod <= (r_umod == c_dst_last) ? '0 : r_umod + NODE_W'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifmap_mem_node_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifmap_mem_node_sync
// Brief   : Directed testbench for ifmap_mem_node_sync.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifmap_mem_node_sync;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        load_done;
  logic        mode;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ts;
  logic [9:0]  wr_addr;
  logic        wr_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [39:0] pkt_data;
  logic        busy;
  logic        send_done;
  logic        err_addr;

  int vectors;
  int errors;
  int pat;

  ifmap_mem_node_sync dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_done  (load_done),
    .mode       (mode),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_ts      (wr_ts),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .busy       (busy),
    .send_done  (send_done),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // pat 0: checkerboard (odd bits in ts0, even bits in ts1); pat 1: all zero.
  function automatic logic [39:0] exp_pkt(input int t, input int r, input int d);
    logic [24:0] p;
    p = '0;
    for (int c = 0; c < 25; c++)
      if (pat == 0) p[c] = ((((r*25 + c) % 2) == 1) ^ (t == 1));
    return {d[3:0], 4'd12, t[1:0], r[4:0], p};
  endfunction

  task automatic load_checker(input logic m);
    pat = 0;
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    vectors++;
    if (wr_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_open: wr_ready=%b busy=%b, want 1 1", wr_ready, busy);
    end
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 625; i++) begin
        wr_valid = 1'b1;
        wr_ts    = t[1:0];
        wr_addr  = i[9:0];
        wr_data  = (((i % 2) == 1) ^ (t == 1));
        if (t == 1 && i == 624) begin
          load_done = 1'b1;
          mode      = m;
        end
        @(negedge clk);
      end
    end
    wr_valid  = 1'b0;
    load_done = 1'b0;
    vectors++;
    if (wr_ready !== 1'b0 || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL send_entry: wr_ready=%b pkt_valid=%b, want 0 1", wr_ready, pkt_valid);
    end
  endtask

  task automatic stream(input logic m, input int nexp, input int stall_at, input int ls_at);
    int n, stalls, cyc, t, r, d;
    bit fired;
    logic [39:0] e;
    n = 0; stalls = 0; cyc = 0; fired = 0;
    while (n < nexp && cyc < nexp + 50) begin
      if (m) begin d = n % 5; t = (n / 5) / 25; r = (n / 5) % 25; end
      else   begin t = n / 25; r = n % 25; d = r % 5; end
      e = exp_pkt(t, r, 1 + d);
      vectors++;
      if (pkt_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid pkt %0d: pkt_valid=%b, want 1", n, pkt_valid);
      end else if (pkt_data !== e) begin
        errors++;
        $display("FAIL stream_data pkt %0d: got %h, want %h", n, pkt_data, e);
      end
      if (!m && pat == 0) begin
        case (n)
          0: begin
            vectors++;
            if (pkt_data !== {4'd1, 4'd12, 2'd0, 5'd0, 25'h0AAAAAA}) begin
              errors++; $display("FAIL ts0_row0: got %h", pkt_data);
            end
          end
          1: begin
            vectors++;
            if (pkt_data !== {4'd2, 4'd12, 2'd0, 5'd1, 25'h1555555}) begin
              errors++; $display("FAIL ts0_row1: got %h", pkt_data);
            end
          end
          5: begin
            vectors++;
            if (pkt_data[39:36] !== 4'd1) begin
              errors++; $display("FAIL ts0_row5_dest: got %0d, want 1", pkt_data[39:36]);
            end
          end
          25: begin
            vectors++;
            if (pkt_data !== {4'd1, 4'd12, 2'd1, 5'd0, 25'h1555555}) begin
              errors++; $display("FAIL ts1_row0: got %h", pkt_data);
            end
          end
          default: ;
        endcase
      end
      if (n == stall_at && stalls < 3) begin
        pkt_ready = 1'b0;
        stalls++;
      end else begin
        pkt_ready = 1'b1;
        if (pkt_valid === 1'b1) n++;
      end
      if (n == ls_at && !fired) begin
        load_start = 1'b1;
        fired = 1;
      end else begin
        load_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    load_start = 1'b0;
    pkt_ready  = 1'b1;
    vectors++;
    if (n < nexp) begin
      errors++;
      $display("FAIL stream_count: got %0d packets, want %0d", n, nexp);
    end
    vectors++;
    if (send_done !== 1'b1 || busy !== 1'b0 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL send_done: send_done=%b busy=%b pkt_valid=%b, want 1 0 0",
               send_done, busy, pkt_valid);
    end
    @(negedge clk);
    vectors++;
    if (send_done !== 1'b0) begin
      errors++;
      $display("FAIL send_done_pulse: send_done=%b, want 0", send_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 0; load_done = 0; mode = 0; wr_valid = 0;
    wr_ts = '0; wr_addr = '0; wr_data = 0; pkt_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({wr_ready, pkt_valid, busy, send_done, err_addr} !== 5'b0 || pkt_data !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b data=%h, want 00000 0",
               {wr_ready, pkt_valid, busy, send_done, err_addr}, pkt_data);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b wr_ready=%b, want 0 0", busy, wr_ready);
    end
  endtask

  task automatic test_unicast();
    load_checker(1'b0);
    stream(1'b0, 50, 7, 20);
  endtask

  task automatic test_broadcast();
    load_checker(1'b1);
    stream(1'b1, 250, 103, -1);
  endtask

  task automatic test_addr_err();
    pat = 1;
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    wr_valid = 1'b1; wr_ts = 2'd0; wr_addr = 10'd625; wr_data = 1'b1;
    vectors++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL err_handshake: wr_ready=%b, want 1", wr_ready);
    end
    @(negedge clk);
    vectors++;
    if (err_addr !== 1'b1) begin
      errors++; $display("FAIL err_addr_set: err_addr=%b, want 1", err_addr);
    end
    wr_ts = 2'd2; wr_addr = 10'd0;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (err_addr !== 1'b1) begin
      errors++; $display("FAIL err_addr_sticky: err_addr=%b, want 1", err_addr);
    end
    load_done = 1'b1; mode = 1'b0;
    @(negedge clk);
    load_done = 1'b0;
    stream(1'b0, 50, -1, -1);
    vectors++;
    if (err_addr !== 1'b1) begin
      errors++; $display("FAIL err_addr_after_send: err_addr=%b, want 1", err_addr);
    end
  endtask

  task automatic test_ctrl_corner();
    @(negedge clk) begin load_start = 1'b1; load_done = 1'b1; end
    @(negedge clk) begin load_start = 1'b0; load_done = 1'b0; end
    vectors++;
    if (wr_ready !== 1'b1 || busy !== 1'b1 || pkt_valid !== 1'b0 || err_addr !== 1'b0) begin
      errors++;
      $display("FAIL start_and_done: wr_ready=%b busy=%b pkt_valid=%b err_addr=%b, want 1 1 0 0",
               wr_ready, busy, pkt_valid, err_addr);
    end
    @(negedge clk);
    vectors++;
    if (wr_ready !== 1'b1 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL stays_in_load: wr_ready=%b pkt_valid=%b, want 1 0", wr_ready, pkt_valid);
    end
  endtask

  task automatic test_reset_mid_send();
    int n, cyc;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    load_checker(1'b0);
    n = 0; cyc = 0;
    while (n < 10 && cyc < 60) begin
      pkt_ready = 1'b1;
      if (pkt_valid === 1'b1) n++;
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    vectors++;
    if ({wr_ready, pkt_valid, busy, send_done, err_addr} !== 5'b0 || pkt_data !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid_send: ctl=%b data=%h, want 00000 0",
               {wr_ready, pkt_valid, busy, send_done, err_addr}, pkt_data);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_send_idle: busy=%b pkt_valid=%b, want 0 0", busy, pkt_valid);
    end
    load_checker(1'b0);
    stream(1'b0, 50, -1, -1);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    pat     = 0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_addr_err();
    test_ctrl_corner();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
